// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch control slice.
package stopwatch_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int MS_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms_10;
  } time_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter and a rising-edge
// press pulse on the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= btn_raw;
      r_sync <= r_meta;
    end
  end

  // The level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync == r_level) begin
      r_cnt   <= '0;
      r_level <= r_level;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_cnt   <= '0;
      r_level <= r_sync;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_level <= r_level;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/LAP/PAUSE FSM,
// lap snapshot and registered display time bus.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_lap,
  input  logic             btn_clr,
  input  logic [MIN_W-1:0] min_i,
  input  logic [SEC_W-1:0] sec_i,
  input  logic [MS_W-1:0]  ms_10_i,
  output logic             run_en,
  output logic             clr_o,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic [MS_W-1:0]  ms_10_o,
  output logic             lap_valid,
  output logic [1:0]       state_o
);

  logic       w_ev_ss;
  logic       w_ev_lap;
  logic       w_ev_clr;
  logic [2:0] w_unused_levels;

  state_t r_state;
  state_t w_next;
  logic   w_clr;
  logic   w_cap;
  time_t  w_live;
  time_t  w_disp_next;

  logic   r_run_en;
  logic   r_lap_valid;
  logic   r_clr;
  time_t  r_lap;
  time_t  r_disp;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .level   (w_unused_levels[0]),
    .press   (w_ev_ss)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lap),
    .level   (w_unused_levels[1]),
    .press   (w_ev_lap)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr),
    .level   (w_unused_levels[2]),
    .press   (w_ev_clr)
  );

  assign w_live = {min_i, sec_i, ms_10_i};

  // Next state with clr > ss > lap priority, restricted to events legal in each state.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev_clr) begin
          w_clr = 1'b1;
        end else if (w_ev_ss) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_ev_ss) begin
          w_next = ST_PAUSE;
        end else if (w_ev_lap) begin
          w_next = ST_LAP;
          w_cap  = 1'b1;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_LAP: begin
        if (w_ev_ss) begin
          w_next = ST_PAUSE;
        end else if (w_ev_lap) begin
          w_cap = 1'b1;
        end else begin
          w_next = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (w_ev_clr) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end else if (w_ev_ss) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_PAUSE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // A fresh capture is shown on the same edge that enters or stays in LAP.
  always_comb begin
    w_disp_next = w_live;
    if (w_cap) begin
      w_disp_next = w_live;
    end else if (w_next == ST_LAP) begin
      w_disp_next = r_lap;
    end else begin
      w_disp_next = w_live;
    end
  end

  // FSM state and its registered decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run_en    <= 1'b0;
      r_lap_valid <= 1'b0;
      r_clr       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_run_en    <= (w_next == ST_RUN) || (w_next == ST_LAP);
      r_lap_valid <= (w_next == ST_LAP);
      r_clr       <= w_clr;
    end
  end

  // Lap snapshot and display bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap  <= '0;
      r_disp <= '0;
    end else begin
      if (w_cap) begin
        r_lap <= w_live;
      end else begin
        r_lap <= r_lap;
      end
      r_disp <= w_disp_next;
    end
  end

  assign run_en    = r_run_en;
  assign lap_valid = r_lap_valid;
  assign clr_o     = r_clr;
  assign state_o   = r_state;
  assign min_o     = r_disp.min;
  assign sec_o     = r_disp.sec;
  assign ms_10_o   = r_disp.ms_10;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It takes three raw push-buttons (start/stop, lap, clear), synchronises and debounces them, and runs a four-state FSM that produces the run enable and clear pulse for the `counter_core` time base. It captures a lap snapshot of the live min/sec/10 ms value and drives the display-side time bus, which shows either the live value or the frozen lap value. It sits between the board buttons, `counter_core` and the display driver.

## Interface
- `DB_CYCLES`, default 1000000: number of consecutive clk cycles a synchronised button level must differ from its debounced level before the debounced level flips (20 ms at 50 MHz). Legal range is 2..2^21-1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `btn_ss`, `btn_lap`, `btn_clr`  in  1 each  raw buttons, active-high, asynchronous to clk.
- `min_i`  in  6  live minutes from `counter_core`.
- `sec_i`  in  6  live seconds.
- `ms_10_i`  in  7  live 10 ms count.
- `run_en`  out  1  level; high means the time base is allowed to advance.
- `clr_o`  out  1  one-cycle clear pulse; inverted at top level for the counter's active-low clear.
- `min_o`  out  6  display minutes.
- `sec_o`  out  6  display seconds.
- `ms_10_o`  out  7  display 10 ms.
- `lap_valid`  out  1  high while the display shows the lap snapshot.
- `state_o`  out  2  current FSM state (encoding below).

## Operation
Each button has its own conditioning chain:
- 2-FF synchroniser.
- A debounce counter that resets whenever the synchronised level equals the debounced level.
- A rising-edge detector on the debounced level, which produces the event pulses `ev_ss`, `ev_lap` and `ev_clr`. Each pulse is 1 cycle wide.
- Releases produce no event.

FSM states are IDLE=0, RUN=1, LAP=2, PAUSE=3.
- IDLE:
  - `ev_ss` → RUN.
  - `ev_clr` → `clr_o` pulse, stay in IDLE.
  - `ev_lap` is ignored.
- RUN:
  - `ev_ss` → PAUSE.
  - `ev_lap` → capture the lap, go to LAP.
  - `ev_clr` is ignored.
- LAP:
  - `ev_lap` → recapture the lap, stay in LAP.
  - `ev_ss` → PAUSE; the display returns to live.
  - `ev_clr` is ignored.
- PAUSE:
  - `ev_ss` → RUN.
  - `ev_clr` → `clr_o` pulse and go to IDLE.
  - `ev_lap` is ignored.

Output rules:
- `run_en` is high in RUN and LAP, and low in IDLE and PAUSE.
- `lap_valid` is high in LAP only.

Simultaneous events in one cycle: the priority is clr > ss > lap. Only the highest-priority event that is legal in the current state is acted on. The rest are discarded, not queued.

Lap capture: on the accepted `ev_lap` cycle, the lap registers load `{min_i, sec_i, ms_10_i}` as sampled at that clk edge.

Display bus:
- It is registered.
- In LAP it holds the lap registers.
- Otherwise it follows the live inputs with 1 cycle of latency.

Widths are fixed at 6/6/7. No arithmetic is done on the time values; they pass through or are held.

Reset (asynchronous, at any time, including mid-debounce or in LAP) forces:
- state IDLE;
- `run_en`=0, `clr_o`=0, `lap_valid`=0;
- the lap registers, `min_o`, `sec_o` and `ms_10_o` all to 0;
- the synchroniser flops, debounced levels and debounce counters to 0.

A button that is still held when reset releases produces an event once it has been stable for `DB_CYCLES`.

## Timing
- Event latency: raw rises and is first sampled high at edge N; the synchronised level is high at N+1; the debounced level flips at N+1+`DB_CYCLES`; the `ev_*` pulse is high in the cycle after that flip.
- Glitches shorter than `DB_CYCLES` cycles, measured at the synchroniser output, produce no event.
- A state change and its `run_en`/`lap_valid` update take effect on the edge that samples the accepted `ev_*`, i.e. 1 cycle after the pulse.
- `clr_o` is registered and high for exactly 1 cycle, the cycle after the accepted `ev_clr`.
- `min_o`, `sec_o` and `ms_10_o` lag the inputs by 1 cycle outside LAP.
- On entry to LAP, the display shows the captured value from the same edge that sets `lap_valid`.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (IDLE/RUN/LAP/PAUSE with the encoding above);
  - the width constants `MIN_W`=6, `SEC_W`=6, `MS_W`=7;
  - a packed time struct {min, sec, ms_10}.
- Sub-module `btn_debounce` (param `DB_CYCLES`; ports `clk`, `rst`, `btn_raw`, `level`, `press`) is instantiated 3 times.
- The FSM, the lap registers and the display mux live in `stopwatch_ctrl`.

## Test plan
All scenarios use `DB_CYCLES`=4.
- Reset, then a 3-cycle `btn_ss` pulse → no event, state 0, `run_en`=0, all outputs 0.
- `btn_ss` held 10 cycles → exactly one `ev_ss`; state goes to 1 and `run_en`=1 on the edge after the pulse; releasing gives no further event.
- In RUN with live inputs 1:23:45, press lap → state 2 and `lap_valid`=1. The display holds 1/23/45 while the inputs advance to 1:24:10. Press lap again at 2:00:05 → the display becomes 2/0/5.
- In LAP, press ss → state 3, `run_en`=0, `lap_valid`=0, display live. Then press clr → `clr_o` high for exactly 1 cycle and state 0.
- In PAUSE, `btn_clr` and `btn_ss` rise on the same cycle → only the clear is acted on: state 0 and 1 `clr_o` pulse, no transition to RUN.
- Assert `rst` mid-debounce while in LAP → all outputs 0 immediately, no event emitted, and operation resumes normally after `rst` falls.
